// File: rtl/db_pkg.sv
// Shared types and helpers for the multi-channel debouncer.
package db_pkg;

   // Per-channel debounce state. The 2-bit encoding is fixed so that the
   // state register has a known layout in every channel.
   typedef enum logic [1:0] {
      LO      = 2'b00,
      WAIT_HI = 2'b01,
      HI      = 2'b10,
      WAIT_LO = 2'b11
   } state_t;

   // Number of bits needed to hold values 0 .. value-1 (minimum 1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) begin
         r = r + 1;
      end
      if (r == 0) begin
         r = 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/db_chan.sv
// One debounce channel: input synchroniser, 4-state FSM with a tick-based
// stability counter, and registered level / rise / fall outputs.
module db_chan
   import db_pkg::*;
#(
   parameter int N_TICKS     = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic sw_bit,
   output logic db,
   output logic db_rise,
   output logic db_fall
);

   localparam int CNT_W = clog2(N_TICKS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_TICKS - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   s;
   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic                   db_reg, db_next;
   logic                   rise_reg, fall_reg;

   // Synchroniser chain: stage 0 samples the raw pin, each later stage
   // copies the one before it.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_reg[0] <= 1'b0;
      end else begin
         sync_reg[0] <= sw_bit;
      end
   end

   generate
      for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
         // Later synchroniser stage.
         always_ff @(posedge clk) begin
            if (reset) begin
               sync_reg[gi] <= 1'b0;
            end else begin
               sync_reg[gi] <= sync_reg[gi-1];
            end
         end
      end
   endgenerate

   assign s = sync_reg[SYNC_STAGES-1];

   // Next-state logic: a changed input must survive N_TICKS ticks before
   // the output follows; returning to the current level aborts the wait.
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      case (state_reg)
         LO: begin
            if (s) begin
               state_next = WAIT_HI;
               cnt_next   = '0;
            end
         end
         WAIT_HI: begin
            if (!s) begin
               state_next = LO;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = HI;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         HI: begin
            if (!s) begin
               state_next = WAIT_LO;
               cnt_next   = '0;
            end
         end
         WAIT_LO: begin
            if (s) begin
               state_next = HI;
            end else if (tick) begin
               if (cnt_reg == CNT_LAST) begin
                  state_next = LO;
               end else begin
                  cnt_next = cnt_reg + CNT_W'(1);
               end
            end
         end
         default: begin
            state_next = LO;
            cnt_next   = '0;
         end
      endcase
      db_next = (state_next == HI) || (state_next == WAIT_LO);
   end

   // State, counter and output flops; strobes compare the new level with
   // the current one so they line up with the first cycle of the new db.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= LO;
         cnt_reg   <= '0;
         db_reg    <= 1'b0;
         rise_reg  <= 1'b0;
         fall_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         db_reg    <= db_next;
         rise_reg  <= db_next & ~db_reg;
         fall_reg  <= ~db_next & db_reg;
      end
   end

   assign db      = db_reg;
   assign db_rise = rise_reg;
   assign db_fall = fall_reg;

endmodule

// File: rtl/db_multi.sv
// Multi-channel debouncer: one shared free-running tick generator feeding
// N_CH independent debounce channels.
module db_multi
   import db_pkg::*;
#(
   parameter int N_CH        = 4,
   parameter int TICK_W      = 19,
   parameter int N_TICKS     = 3,
   parameter int SYNC_STAGES = 2
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] sw,
   output logic [N_CH-1:0] db,
   output logic [N_CH-1:0] db_rise,
   output logic [N_CH-1:0] db_fall
);

   logic [TICK_W-1:0] tick_cnt_reg;
   logic              tick;

   // Free-running tick counter; wraps every 2^TICK_W cycles.
   always_ff @(posedge clk) begin
      if (reset) begin
         tick_cnt_reg <= '0;
      end else begin
         tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
      end
   end

   assign tick = &tick_cnt_reg;

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
         db_chan #(
            .N_TICKS     (N_TICKS),
            .SYNC_STAGES (SYNC_STAGES)
         ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .tick    (tick),
            .sw_bit  (sw[gi]),
            .db      (db[gi]),
            .db_rise (db_rise[gi]),
            .db_fall (db_fall[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_db_multi.sv
// Bench for db_multi: two instances (N_TICKS=3 and N_TICKS=1) compared each
// cycle against a run-length/tick-count model of the debouncing rules.
module tb_db_multi;

   localparam int TICK_W = 3;
   localparam int TICK_P = 1 << TICK_W;
   localparam int NT_A   = 3;
   localparam int NT_B   = 1;

   logic       clk;
   logic       reset;
   logic [1:0] sw_a, sw_b;
   logic [1:0] db_a, db_rise_a, db_fall_a;
   logic [1:0] db_b, db_rise_b, db_fall_b;

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: per instance d, per channel ch.
   int         cyc;
   bit         m_db   [2][2];
   bit         m_prev [2][2];
   bit         m_act  [2][2];
   int         m_ticks[2][2];
   bit         m_h1   [2][2];
   bit         m_h2   [2][2];
   logic [5:0] exp_v  [2];

   db_multi #(.N_CH(2), .TICK_W(TICK_W), .N_TICKS(NT_A), .SYNC_STAGES(2)) dut_a (
      .clk(clk), .reset(reset), .sw(sw_a),
      .db(db_a), .db_rise(db_rise_a), .db_fall(db_fall_a)
   );

   db_multi #(.N_CH(2), .TICK_W(TICK_W), .N_TICKS(NT_B), .SYNC_STAGES(2)) dut_b (
      .clk(clk), .reset(reset), .sw(sw_b),
      .db(db_b), .db_rise(db_rise_b), .db_fall(db_fall_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and update the model. A channel's synchronised input
   // is the raw input two cycles earlier. Whenever it differs from db a run
   // starts; ticks seen after the run's first cycle are counted, and once
   // the count reaches N_TICKS the level flips. Returning to db ends the run.
   task automatic step();
      bit         tk;
      bit         s;
      int         nt;
      logic [1:0] swv;
      @(posedge clk);
      if (reset) begin
         cyc = 0;
         for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < 2; ch++) begin
               m_db[d][ch] = 0; m_prev[d][ch] = 0; m_act[d][ch] = 0;
               m_ticks[d][ch] = 0; m_h1[d][ch] = 0; m_h2[d][ch] = 0;
            end
         end
      end else begin
         tk = (cyc % TICK_P) == (TICK_P - 1);
         for (int d = 0; d < 2; d++) begin
            nt  = (d == 0) ? NT_A : NT_B;
            swv = (d == 0) ? sw_a : sw_b;
            for (int ch = 0; ch < 2; ch++) begin
               s = m_h2[d][ch];
               m_prev[d][ch] = m_db[d][ch];
               if (s == m_db[d][ch]) begin
                  m_act[d][ch] = 0;
               end else if (!m_act[d][ch]) begin
                  m_act[d][ch] = 1;
                  m_ticks[d][ch] = 0;
               end else if (tk) begin
                  m_ticks[d][ch]++;
                  if (m_ticks[d][ch] == nt) begin
                     m_db[d][ch] = ~m_db[d][ch];
                     m_act[d][ch] = 0;
                  end
               end
               m_h2[d][ch] = m_h1[d][ch];
               m_h1[d][ch] = swv[ch];
            end
         end
         cyc++;
      end
      for (int d = 0; d < 2; d++) begin
         exp_v[d] = {m_db[d][1], m_db[d][0],
                     m_db[d][1] & ~m_prev[d][1], m_db[d][0] & ~m_prev[d][0],
                     ~m_db[d][1] & m_prev[d][1], ~m_db[d][0] & m_prev[d][0]};
      end
      @(negedge clk);
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      repeat (n) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      sw_a = 2'b00; sw_b = 2'b00;
      do_reset(2);
      n_tests++; if ({db_a, db_rise_a, db_fall_a} !== 6'b0) begin n_fail++; $display("FAIL reset_a got=%b exp=000000", {db_a, db_rise_a, db_fall_a}); end
      n_tests++; if ({db_b, db_rise_b, db_fall_b} !== 6'b0) begin n_fail++; $display("FAIL reset_b got=%b exp=000000", {db_b, db_rise_b, db_fall_b}); end
   endtask

   task automatic test_rise();
      sw_a = 2'b01;
      while (cyc <= 30) begin
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL rise_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         if (cyc == 23) begin n_tests++; if (db_a !== 2'b00) begin n_fail++; $display("FAIL rise_early cyc=23 got=%b exp=00", db_a); end end
         if (cyc == 24) begin n_tests++; if ({db_a, db_rise_a} !== 4'b0101) begin n_fail++; $display("FAIL rise_edge cyc=24 got=%b exp=0101", {db_a, db_rise_a}); end end
         if (cyc == 25) begin n_tests++; if ({db_a, db_rise_a} !== 4'b0100) begin n_fail++; $display("FAIL rise_strobe_len cyc=25 got=%b exp=0100", {db_a, db_rise_a}); end end
         step();
      end
   endtask

   task automatic test_fall();
      while (cyc <= 70) begin
         if (cyc == 40) sw_a[0] = 1'b0;
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL fall_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         if (cyc == 63) begin n_tests++; if ({db_a[0], db_fall_a[0]} !== 2'b10) begin n_fail++; $display("FAIL fall_early cyc=63 got=%b exp=10", {db_a[0], db_fall_a[0]}); end end
         if (cyc == 64) begin n_tests++; if ({db_a[0], db_fall_a[0]} !== 2'b01) begin n_fail++; $display("FAIL fall_edge cyc=64 got=%b exp=01", {db_a[0], db_fall_a[0]}); end end
         if (cyc == 65) begin n_tests++; if ({db_a[0], db_fall_a[0]} !== 2'b00) begin n_fail++; $display("FAIL fall_strobe_len cyc=65 got=%b exp=00", {db_a[0], db_fall_a[0]}); end end
         step();
      end
   endtask

   task automatic test_bounce();
      do_reset(1);
      while (cyc <= 40) begin
         sw_a[1] = (cyc <= 4) || (cyc >= 10 && cyc <= 12);
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL bounce_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         n_tests++; if ({db_a[1], db_rise_a[1], db_fall_a[1]} !== 3'b000) begin n_fail++; $display("FAIL bounce_quiet cyc=%0d got=%b exp=000", cyc, {db_a[1], db_rise_a[1], db_fall_a[1]}); end
         step();
      end
   endtask

   task automatic test_glitch();
      int k;
      k = 0;
      sw_a = 2'b01;
      while (db_a[0] !== 1'b1 && k < 60) begin
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL glitch_setup_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         step();
         k++;
      end
      n_tests++; if (db_a[0] !== 1'b1) begin n_fail++; $display("FAIL glitch_setup_timeout got=%b exp=1", db_a[0]); end
      step();
      for (int i = 0; i < 46; i++) begin
         sw_a[0] = (i >= 6);
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL glitch_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         n_tests++; if ({db_a[0], db_rise_a[0], db_fall_a[0]} !== 3'b100) begin n_fail++; $display("FAIL glitch_hold cyc=%0d got=%b exp=100", cyc, {db_a[0], db_rise_a[0], db_fall_a[0]}); end
         step();
      end
   endtask

   task automatic test_reset_mid();
      sw_b = 2'b01;
      sw_a[0] = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL rmid_model cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         step();
      end
      n_tests++; if (db_a[0] !== 1'b1) begin n_fail++; $display("FAIL rmid_waitlo got=%b exp=1", db_a[0]); end
      do_reset(1);
      n_tests++; if ({db_a[0], db_fall_a[0]} !== 2'b00) begin n_fail++; $display("FAIL rmid_cleared got=%b exp=00", {db_a[0], db_fall_a[0]}); end
      while (cyc <= 12) begin
         n_tests++; if ({db_b, db_rise_b, db_fall_b} !== exp_v[1]) begin n_fail++; $display("FAIL rmid_model_b cyc=%0d got=%b exp=%b", cyc, {db_b, db_rise_b, db_fall_b}, exp_v[1]); end
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL rmid_model_a cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         if (cyc == 7) begin n_tests++; if (db_b[0] !== 1'b0) begin n_fail++; $display("FAIL rmid_tick_early cyc=7 got=%b exp=0", db_b[0]); end end
         if (cyc == 8) begin n_tests++; if ({db_b[0], db_rise_b[0]} !== 2'b11) begin n_fail++; $display("FAIL rmid_tick_restart cyc=8 got=%b exp=11", {db_b[0], db_rise_b[0]}); end end
         step();
      end
   endtask

   task automatic test_simultaneous();
      do_reset(1);
      sw_a = 2'b11; sw_b = 2'b11;
      while (cyc <= 26) begin
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL simul_model_a cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         n_tests++; if ({db_b, db_rise_b, db_fall_b} !== exp_v[1]) begin n_fail++; $display("FAIL simul_model_b cyc=%0d got=%b exp=%b", cyc, {db_b, db_rise_b, db_fall_b}, exp_v[1]); end
         if (cyc == 8)  begin n_tests++; if ({db_b, db_rise_b} !== 4'b1111) begin n_fail++; $display("FAIL simul_nt1 cyc=8 got=%b exp=1111", {db_b, db_rise_b}); end end
         if (cyc == 9)  begin n_tests++; if ({db_b, db_rise_b} !== 4'b1100) begin n_fail++; $display("FAIL simul_nt1_len cyc=9 got=%b exp=1100", {db_b, db_rise_b}); end end
         if (cyc == 24) begin n_tests++; if ({db_a, db_rise_a} !== 4'b1111) begin n_fail++; $display("FAIL simul_nt3 cyc=24 got=%b exp=1111", {db_a, db_rise_a}); end end
         step();
      end
   endtask

   task automatic test_random();
      int hold_a, hold_b;
      hold_a = 0; hold_b = 0;
      for (int i = 0; i < 3000; i++) begin
         n_tests++; if ({db_a, db_rise_a, db_fall_a} !== exp_v[0]) begin n_fail++; $display("FAIL rand_model_a cyc=%0d got=%b exp=%b", cyc, {db_a, db_rise_a, db_fall_a}, exp_v[0]); end
         n_tests++; if ({db_b, db_rise_b, db_fall_b} !== exp_v[1]) begin n_fail++; $display("FAIL rand_model_b cyc=%0d got=%b exp=%b", cyc, {db_b, db_rise_b, db_fall_b}, exp_v[1]); end
         if (hold_a == 0) begin
            sw_a[$urandom_range(0, 1)] ^= 1'b1;
            hold_a = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(10, 40);
         end else hold_a--;
         if (hold_b == 0) begin
            sw_b[$urandom_range(0, 1)] ^= 1'b1;
            hold_b = ($urandom_range(0, 1) != 0) ? $urandom_range(1, 6) : $urandom_range(10, 40);
         end else hold_b--;
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      sw_a = 2'b00;
      sw_b = 2'b00;
      cyc = 0;
      @(negedge clk);
      test_reset();
      test_rise();
      test_fall();
      test_bounce();
      test_glitch();
      test_reset_mid();
      test_simultaneous();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
